// File: rtl/mna_noc_pkg.sv
// Shared constants for the MNA request path: flit type codes, header field offsets, packetizer FSM encoding.
package mna_noc_pkg;

  localparam logic [1:0] FLIT_HDR  = 2'b10;
  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b01;

  localparam int unsigned HDR_DST_LSB = 28;
  localparam int unsigned HDR_SRC_LSB = 24;
  localparam int unsigned HDR_SEQ_LSB = 1;
  localparam int unsigned HDR_RW_BIT  = 0;
  localparam int unsigned SEQ_W       = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

endpackage

// File: rtl/mna_vc_encoder.sv
// One-hot VC grant to binary VC id, plus a flag that the grant is exactly one-hot.
module mna_vc_encoder
  import mna_noc_pkg::*;
#(
  parameter  int unsigned VC_NUM = 8,
  localparam int unsigned VC_W   = $clog2(VC_NUM)
) (
  input  logic [VC_NUM-1:0] grant,
  output logic [VC_W-1:0]   vc_id,
  output logic              onehot_ok
);

  always_comb begin
    vc_id = '0;
    for (int unsigned i = 0; i < VC_NUM; i++) begin
      if (grant[i]) vc_id = vc_id | VC_W'(i);
    end
    // clearing the lowest set bit leaves zero only for a single-bit grant
    onehot_ok = (grant != '0) && ((grant & (grant - VC_NUM'(1))) == '0);
  end

endmodule

// File: rtl/mna_flit_packetizer.sv
// Captures one AXI-Lite request and emits header/body/tail flits over a valid/ready link.
// Optional MNA_FLIT_PACKETIZER_SEQ_EN adds an 8-bit packet sequence number in header[8:1].
module mna_flit_packetizer
  import mna_noc_pkg::*;
#(
  parameter  logic [3:0]  SRC_ADDR = 4'b0001,
  parameter  int unsigned DATA_W   = 32,
  parameter  int unsigned VC_NUM   = 8,
  localparam int unsigned VC_W     = $clog2(VC_NUM),
  localparam int unsigned FLIT_W   = 2 + VC_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [VC_NUM-1:0] vc_grant,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [FLIT_W-1:0] flit_data,
  output logic              pkt_busy
);

  logic [1:0]        state;
  logic              cap_write;
  logic [DATA_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [VC_W-1:0]   cap_vc;
  logic [VC_W-1:0]   enc_vc;
  logic              enc_ok;
  logic [1:0]        ftype;
  logic [DATA_W-1:0] payload;
`ifdef MNA_FLIT_PACKETIZER_SEQ_EN
  logic [SEQ_W-1:0]  seq_cnt;
  logic [SEQ_W-1:0]  cap_seq;
`endif

  mna_vc_encoder #(.VC_NUM(VC_NUM)) u_vc_enc (
    .grant     (vc_grant),
    .vc_id     (enc_vc),
    .onehot_ok (enc_ok)
  );

  assign req_ready  = (state == ST_IDLE) && !rst && enc_ok;
  assign flit_valid = (state != ST_IDLE);
  assign pkt_busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_vc    <= '0;
`ifdef MNA_FLIT_PACKETIZER_SEQ_EN
      seq_cnt   <= '0;
      cap_seq   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            state     <= ST_HDR;
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_vc    <= enc_vc;
`ifdef MNA_FLIT_PACKETIZER_SEQ_EN
            cap_seq   <= seq_cnt;
            seq_cnt   <= seq_cnt + SEQ_W'(1);
`endif
          end
        end
        ST_HDR:  if (flit_ready) state <= cap_write ? ST_BODY : ST_TAIL;
        ST_BODY: if (flit_ready) state <= ST_TAIL;
        ST_TAIL: if (flit_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Flit is decoded from state and captured fields, so it holds steady through any stall.
  always_comb begin
    ftype   = FLIT_BODY;
    payload = '0;
    case (state)
      ST_HDR: begin
        ftype                       = FLIT_HDR;
        payload[HDR_DST_LSB +: 4]   = cap_addr[31:28];
        payload[HDR_SRC_LSB +: 4]   = SRC_ADDR;
        payload[HDR_RW_BIT]         = ~cap_write;
`ifdef MNA_FLIT_PACKETIZER_SEQ_EN
        payload[HDR_SEQ_LSB +: SEQ_W] = cap_seq;
`endif
      end
      ST_BODY: payload = cap_addr;
      ST_TAIL: begin
        ftype   = FLIT_TAIL;
        payload = cap_write ? cap_wdata : cap_addr;
      end
      default: ;
    endcase
    flit_data = (state == ST_IDLE) ? '0 : {ftype, cap_vc, payload};
  end

endmodule

// File: tb/tb_mna_flit_packetizer.sv
// Bench for mna_flit_packetizer: vector table, hand sequences and random packets against a flit-list model.
module tb_mna_flit_packetizer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  vc_grant;
  logic        flit_valid;
  logic        flit_ready;
  logic [36:0] flit_data;
  logic        pkt_busy;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [7:0]  model_seq = 8'd0;

  mna_flit_packetizer #(.SRC_ADDR(4'b0001), .DATA_W(32), .VC_NUM(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .vc_grant   (vc_grant),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .flit_data  (flit_data),
    .pkt_busy   (pkt_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  grant;
    logic [2:0]  exp_vc;
  } vec_t;

  vec_t vecs[6];

  function automatic bit chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic resync();
    rst = 1'b1;
    req_valid = 1'b0;
    flit_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_seq = 8'd0;
  endtask

  // Entered between a negedge and the following posedge with the DUT idle.
  task automatic do_pkt(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [7:0] g, input logic [2:0] vc,
                        input int unsigned stall_pct, input int unsigned body_stall);
    logic [36:0] q[$];
    logic [31:0] hp;
    int unsigned k, cyc, held;
    logic fr;
    bit ok;
    hp = (a & 32'hF000_0000) | (32'd1 << 24) | (wr ? 32'd0 : 32'd1);
`ifdef MNA_FLIT_PACKETIZER_SEQ_EN
    hp = hp | (32'(model_seq) << 1);
`endif
    q.push_back({2'b10, vc, hp});
    if (wr) q.push_back({2'b00, vc, a});
    q.push_back({2'b01, vc, wr ? d : a});

    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; vc_grant = g; flit_ready = 1'b0;
    #1;
    ok = chk("req_ready_idle", req_ready, 1);
    @(posedge clk);
    model_seq = model_seq + 8'd1;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    vc_grant  = 8'($urandom);
    k = 0; cyc = 0; held = 0;
    while (ok && k < q.size() && cyc < 100) begin
      #1;
      ok = chk("flit_valid", flit_valid, 1) & chk("flit_data", flit_data, q[k])
         & chk("pkt_busy", pkt_busy, 1) & chk("req_ready_busy", req_ready, 0);
      fr = ($urandom_range(99) >= stall_pct);
      if (wr && k == 1 && held < body_stall) begin
        fr = 1'b0;
        held++;
      end
      flit_ready = fr;
      @(posedge clk);
      if (fr) k++;
      @(negedge clk);
      cyc++;
    end
    flit_ready = 1'b0;
    if (!ok || k < q.size()) begin
      if (ok) void'(chk("pkt_timeout", 64'(k), 64'(q.size())));
      resync();
    end else begin
      #1;
      void'(chk("idle_valid", flit_valid, 0));
      void'(chk("idle_busy", pkt_busy, 0));
      void'(chk("idle_data", flit_data, 0));
    end
  endtask

  initial begin
    int unsigned r;
    vecs[0] = '{1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 8'b0000_0100, 3'd2};
    vecs[1] = '{1'b0, 32'h5000_0004, 32'h1234_5678, 8'h80,        3'd7};
    vecs[2] = '{1'b1, 32'hF123_4567, 32'h0000_0000, 8'h01,        3'd0};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 8'h02,        3'd1};
    vecs[4] = '{1'b1, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 8'h10,        3'd4};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0BAD_F00D, 8'h20,        3'd5};

    rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3000_0000;
    req_wdata = 32'h0; vc_grant = 8'h01; flit_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    void'(chk("rst_req_ready", req_ready, 0));
    void'(chk("rst_flit_valid", flit_valid, 0));
    void'(chk("rst_pkt_busy", pkt_busy, 0));
    void'(chk("rst_flit_data", flit_data, 0));
    rst = 1'b0; req_valid = 1'b0; flit_ready = 1'b0;
    #1;
    void'(chk("post_rst_req_ready", req_ready, 1));
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      do_pkt(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].grant, vecs[i].exp_vc, 0, 0);

    // Five-cycle stall while the body flit is presented.
    do_pkt(1'b1, 32'h7000_0100, 32'hCAFE_0001, 8'h08, 3'd3, 0, 5);

    // Zero-hot and multi-hot grants must stall, not drop, the request.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h2000_0000;
    foreach (vecs[i]) begin end
    for (int j = 0; j < 3; j++) begin
      vc_grant = (j == 0) ? 8'h00 : (j == 1) ? 8'h0C : 8'hFF;
      repeat (2) begin
        @(negedge clk);
        #1;
        void'(chk("bad_grant_ready", req_ready, 0));
        void'(chk("bad_grant_busy", pkt_busy, 0));
        void'(chk("bad_grant_valid", flit_valid, 0));
      end
    end
    do_pkt(1'b0, 32'h2000_0000, 32'h0, 8'h01, 3'd0, 0, 0);

    // Reset while the body flit is outstanding abandons the packet.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h9000_0040; req_wdata = 32'h5555_AAAA; vc_grant = 8'h04;
    @(posedge clk);
    model_seq = model_seq + 8'd1;
    @(negedge clk);
    req_valid = 1'b0; flit_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    void'(chk("mid_body_data", flit_data, {2'b00, 3'd2, 32'h9000_0040}));
    flit_ready = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_seq = 8'd0;
    #1;
    void'(chk("rst_mid_valid", flit_valid, 0));
    void'(chk("rst_mid_busy", pkt_busy, 0));
    void'(chk("rst_mid_data", flit_data, 0));
    do_pkt(1'b1, 32'h4000_0008, 32'h0123_4567, 8'h40, 3'd6, 0, 0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(7);
      do_pkt(1'($urandom), $urandom, $urandom, 8'(1) << r, 3'(r), 30, 0);
    end

    resync();
    for (int n = 0; n < 257; n++) begin
      r = $urandom_range(7);
      do_pkt(1'b0, $urandom, $urandom, 8'(1) << r, 3'(r), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
